hedios_packet_tx: RTL and testbench
===================================

Name: hedios_packet_tx

Overview:
Parametrised packet transmitter for the HEDIOS serial link.
- Buffers command+payload packets in an internal FIFO of configurable depth.
- Serialises each packet as a fixed-length byte sequence onto a UART line with configurable stop bits and inter-packet gap.
- Sits between host-side packet producers and the board TX pin.
- Adds level and overflow reporting, a done pulse, and an optional checksum byte.

Parameters:
CLK_RATE, 100_000_000, system clock frequency in Hz
BAUD_RATE, 1_000_000, line bit rate; BIT_CYCLES = CLK_RATE/BAUD_RATE (integer truncation, must be >= 2)
DATA_BYTES, 4, payload bytes per packet (1..16)
FIFO_DEPTH, 8, packet queue depth (power of two, >= 2)
STOP_BITS, 1, stop bits per byte frame (1 or 2)
GAP_BITS, 1, idle bit-times inserted after each packet (0..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
packet_command  in  8  command byte of packet to queue
packet_data  in  8*DATA_BYTES  payload of packet to queue
push_packet  in  1  one-cycle enqueue strobe
overflow_clr  in  1  synchronous clear of overflow flag
queue_full  out  1  level == FIFO_DEPTH
queue_empty  out  1  level == 0
queue_level  out  $clog2(FIFO_DEPTH)+1  packets stored, excluding the one being sent
overflow  out  1  sticky: a push was dropped
busy  out  1  high from pop until end of inter-packet gap
packet_done  out  1  one-cycle pulse at end of last stop bit of a packet
tx_line  out  1  UART output, idle high

Behaviour:
- Reset (async): tx_line=1, FIFO emptied, queue_level=0, queue_empty=1, queue_full=0, overflow=0, busy=0, packet_done=0, FSM=IDLE. Reset mid-frame aborts instantly; the partial frame is not resumed.
- FIFO push:
  - Accepted when push_packet=1 and not full.
  - Push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push+pop on a non-full queue leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by overflow_clr. If set and clear occur in the same cycle, set wins.
- Byte order:
  - Command byte first, then packet_data bytes LSB byte first ([7:0] first).
  - Frame length N = DATA_BYTES+1 bytes.
- Frame format: start bit 0, 8 data bits LSB first, STOP_BITS stop bits of 1. Each bit lasts exactly BIT_CYCLES clocks. No idle time between bytes of one packet.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the packet shift register, set busy, go to SEND.
  - SEND: the byte counter steps 0..N-1; after the last stop bit of byte N-1, pulse packet_done and go to GAP.
  - GAP: tx_line=1 for GAP_BITS*BIT_CYCLES cycles, then go to IDLE and drop busy. With GAP_BITS=0, go straight to IDLE.
- Latency: a push at edge E0 into an empty, idle block is popped at E1; tx_line falls after E2.
- Back-to-back packets: line high between the last data bit and the next start bit for (STOP_BITS+GAP_BITS)*BIT_CYCLES+1 cycles (the +1 is the IDLE pop cycle).
- The popped packet is held in a dedicated register, so FIFO activity never corrupts the packet being sent.

Optional Feature:
HEDIOS_TX_CHECKSUM_EN:
- Defined: one trailing byte is appended, equal to the XOR of the command and all payload bytes; N = DATA_BYTES+2. Sent after the last payload byte, before packet_done.
- Undefined: no checksum logic; N = DATA_BYTES+1.

Test Plan:
Bench setup: CLK_RATE=4_000_000, BAUD_RATE=1_000_000 (BIT_CYCLES=4), DATA_BYTES=4, FIFO_DEPTH=8, STOP_BITS=1, GAP_BITS=1.
- Single packet, cmd 0xA5, data 0x12345678 → bytes A5,78,56,34,12 on tx_line at 40 cycles each. The start bit begins 2 cycles after the push edge. packet_done pulses 200 cycles after the start bit. busy drops 4 cycles later.
- 10 pushes on consecutive cycles → queue_level reaches 8, queue_full=1, 10th push dropped, overflow=1. Exactly 9 packets transmitted in order. An overflow_clr pulse afterwards → overflow=0.
- Two queued packets → line high for exactly 9 cycles between the last data bit of packet 1 and the start bit of packet 2. packet_done pulses twice.
- HEDIOS_TX_CHECKSUM_EN defined, cmd 0xA5, data 0x12345678 → sixth byte 0xAD, packet_done 240 cycles after the start bit.
- rst asserted mid-byte of packet 1 with 3 queued → tx_line=1 immediately, queue_empty=1, queue_level=0, busy=0. No further frames until a new push.
- Push and pop in the same cycle at level 3 → level stays 3, overflow stays 0.

Source files
------------

// File: rtl/hedios_packet_tx.sv
// HEDIOS packet transmitter: queues command+payload packets and serialises each as back-to-back UART bytes.
// Optional build macro HEDIOS_TX_CHECKSUM_EN appends an XOR checksum byte to every packet.
module hedios_packet_tx #(
   parameter int CLK_RATE   = 100_000_000,
   parameter int BAUD_RATE  = 1_000_000,
   parameter int DATA_BYTES = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int GAP_BITS   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    packet_command,
   input  logic [8*DATA_BYTES-1:0]       packet_data,
   input  logic                          push_packet,
   input  logic                          overflow_clr,
   output logic                          queue_full,
   output logic                          queue_empty,
   output logic [$clog2(FIFO_DEPTH):0]   queue_level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          packet_done,
   output logic                          tx_line
);
   localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
   localparam int EW         = 8 + 8*DATA_BYTES;
`ifdef HEDIOS_TX_CHECKSUM_EN
   localparam int NBYTES     = DATA_BYTES + 2;
`else
   localparam int NBYTES     = DATA_BYTES + 1;
`endif
   localparam int PW         = 8*NBYTES;
   localparam int FRAME_BITS = 9 + STOP_BITS;
   localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
   localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int BCW        = $clog2(BIT_CYCLES);
   localparam int FBW        = $clog2(FRAME_BITS);
   localparam int NBW        = $clog2(NBYTES);
   localparam int GCW        = $clog2(GAP_CYCLES + 2);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   state_t state, state_next;

   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           push_ok, pop;
   logic [EW-1:0]  head;
   logic [PW-1:0]  pkt_load, pkt_reg;
   logic [BCW-1:0] bit_cnt;
   logic [FBW-1:0] bit_idx;
   logic [NBW-1:0] byte_idx;
   logic [GCW-1:0] gap_cnt;
   logic           bit_end, frame_end, send_end, gap_end;
   logic [7:0]     cur_byte;
   logic [2:0]     data_sel;
   logic           line_comb, done_comb, done_s1;

   assign queue_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign queue_empty = (count == '0);
   assign queue_level = count;
   assign push_ok     = push_packet && !queue_full;
   assign pop         = (state == IDLE) && !queue_empty;
   assign head        = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {packet_data, packet_command};
   end

   // A push against a full queue is dropped even when a pop frees a slot in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
         if (push_packet && queue_full) overflow <= 1'b1;
         else if (overflow_clr)         overflow <= 1'b0;
      end
   end

`ifdef HEDIOS_TX_CHECKSUM_EN
   logic [7:0] chk;
   always_comb begin
      chk = head[7:0];
      for (int i = 1; i <= DATA_BYTES; i++) chk = chk ^ head[8*i +: 8];
   end
   assign pkt_load = {chk, head};
`else
   assign pkt_load = head;
`endif

   assign bit_end   = (bit_cnt == BCW'(BIT_CYCLES - 1));
   assign frame_end = bit_end && (bit_idx == FBW'(FRAME_BITS - 1));
   assign send_end  = frame_end && (byte_idx == NBW'(NBYTES - 1));
   assign gap_end   = (gap_cnt == GCW'(GAP_LAST));
   assign cur_byte  = pkt_reg[7:0];

   // The packet lives in its own shift register once popped; the low byte is always the one on the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_reg  <= '0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         gap_cnt  <= '0;
      end else if (pop) begin
         pkt_reg  <= pkt_load;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
      end else if (state == SEND) begin
         gap_cnt <= '0;
         if (bit_end) begin
            bit_cnt <= '0;
            if (frame_end) begin
               bit_idx  <= '0;
               byte_idx <= byte_idx + NBW'(1);
               pkt_reg  <= {8'h00, pkt_reg[PW-1:8]};
            end else begin
               bit_idx <= bit_idx + FBW'(1);
            end
         end else begin
            bit_cnt <= bit_cnt + BCW'(1);
         end
      end else if (state == GAP) begin
         gap_cnt <= gap_cnt + GCW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!queue_empty) state_next = SEND;
         SEND:    if (send_end) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      line_comb = 1'b1;
      done_comb = 1'b0;
      data_sel  = 3'(bit_idx - FBW'(1));
      if (state == SEND) begin
         if (bit_idx == '0)            line_comb = 1'b0;
         else if (bit_idx <= FBW'(8))  line_comb = cur_byte[data_sel];
         done_comb = send_end;
      end
   end

   // Outputs are registered; packet_done is delayed a second stage so it lands after the last stop bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_line     <= 1'b1;
         busy        <= 1'b0;
         done_s1     <= 1'b0;
         packet_done <= 1'b0;
      end else begin
         tx_line     <= line_comb;
         busy        <= (state != IDLE);
         done_s1     <= done_comb;
         packet_done <= done_s1;
      end
   end
endmodule

// File: tb/tb_hedios_packet_tx.sv
// Self-checking bench for hedios_packet_tx with BIT_CYCLES=4, DATA_BYTES=4, FIFO_DEPTH=8.
// A UART decoder checks every received byte against the expected byte queue.
module tb_hedios_packet_tx;
`ifdef HEDIOS_TX_CHECKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif
   localparam int PKT_CYC = NB * 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  packet_command = '0;
   logic [31:0] packet_data = '0;
   logic        push_packet = 1'b0;
   logic        overflow_clr = 1'b0;
   logic        queue_full, queue_empty, overflow, busy, packet_done, tx_line;
   logic [3:0]  queue_level;

   hedios_packet_tx #(
      .CLK_RATE(4_000_000), .BAUD_RATE(1_000_000), .DATA_BYTES(4),
      .FIFO_DEPTH(8), .STOP_BITS(1), .GAP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .packet_command(packet_command), .packet_data(packet_data),
      .push_packet(push_packet), .overflow_clr(overflow_clr), .queue_full(queue_full),
      .queue_empty(queue_empty), .queue_level(queue_level), .overflow(overflow),
      .busy(busy), .packet_done(packet_done), .tx_line(tx_line)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int rst_cnt = 0;
   int total = 0;
   int bad = 0;
   int starts[$];
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge rst) rst_cnt = rst_cnt + 1;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
      logic [39:0] seq;
      logic [7:0]  chk;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_vec(input int i, input bit accept);
      packet_command = vecs[i].cmd;
      packet_data    = vecs[i].data;
      push_packet    = 1'b1;
      if (accept) begin
         for (int b = 0; b < 5; b++) exp_q.push_back(vecs[i].seq[39-8*b -: 8]);
`ifdef HEDIOS_TX_CHECKSUM_EN
         exp_q.push_back(vecs[i].chk);
`endif
      end
      step();
      push_packet = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         step();
         if (packet_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no packet_done within %0d cycles", budget);
      end
   endtask

   // UART decoder: samples each bit mid-way, discards frames cut by a reset.
   initial begin : uart_mon
      logic prev;
      logic [7:0] b;
      logic start_v, stop_v;
      int rc, s;
      prev = 1'b1;
      b = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst && prev && !tx_line) begin
            rc = rst_cnt;
            s  = cyc;
            mon_wait(2);
            start_v = tx_line;
            for (int i = 0; i < 8; i++) begin
               mon_wait(4);
               b[i] = tx_line;
            end
            mon_wait(4);
            stop_v = tx_line;
            if (rc == rst_cnt && !rst) begin
               starts.push_back(s);
               check("start_bit", 64'(start_v), 64'd0);
               check("stop_bit", 64'(stop_v), 64'd1);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte: got %0h expected none", b);
               end else begin
                  check("byte", 64'(b), 64'(exp_q.pop_front()));
               end
            end
         end
         prev = tx_line;
      end
   end

   initial begin
      int e0, d0, d1, base, sc;
      vecs[0] = '{8'hA5, 32'h12345678, 40'hA5_78_56_34_12, 8'hAD};
      vecs[1] = '{8'h01, 32'h00000000, 40'h01_00_00_00_00, 8'h01};
      vecs[2] = '{8'hFF, 32'hFFFFFFFF, 40'hFF_FF_FF_FF_FF, 8'hFF};
      vecs[3] = '{8'h00, 32'h80000001, 40'h00_01_00_00_80, 8'h81};
      vecs[4] = '{8'h3C, 32'h11223344, 40'h3C_44_33_22_11, 8'h78};
      vecs[5] = '{8'h55, 32'hAAAAAAAA, 40'h55_AA_AA_AA_AA, 8'h55};
      vecs[6] = '{8'hC3, 32'h0F0F0F0F, 40'hC3_0F_0F_0F_0F, 8'hC3};
      vecs[7] = '{8'h7E, 32'hDEADBEEF, 40'h7E_EF_BE_AD_DE, 8'h5C};
      vecs[8] = '{8'h81, 32'h01020304, 40'h81_04_03_02_01, 8'h85};
      vecs[9] = '{8'h42, 32'hCAFEBABE, 40'h42_BE_BA_FE_CA, 8'h72};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 64'(tx_line), 64'd1);
      check("rst_empty", 64'(queue_empty), 64'd1);
      check("rst_full", 64'(queue_full), 64'd0);
      check("rst_level", 64'(queue_level), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(packet_done), 64'd0);
      rst = 1'b0;
      step();

      // Single packet: latency, byte order, done and busy timing
      base = starts.size();
      e0 = cyc + 1;
      push_vec(0, 1'b1);
      check("a_level_after_push", 64'(queue_level), 64'd1);
      step();
      check("a_level_after_pop", 64'(queue_level), 64'd0);
      check("a_tx_before_start", 64'(tx_line), 64'd1);
      step();
      check("a_tx_start", 64'(tx_line), 64'd0);
      wait_done(PKT_CYC + 20, d0);
      check("a_done_time", 64'(d0), 64'(e0 + 2 + PKT_CYC));
      step();
      check("a_done_pulse_width", 64'(packet_done), 64'd0);
      step();
      step();
      check("a_busy_in_gap", 64'(busy), 64'd1);
      step();
      check("a_busy_drop", 64'(busy), 64'd0);
      check("a_start_time", 64'(starts[base]), 64'(e0 + 2));
      check("a_byte_count", 64'(starts.size() - base), 64'(NB));

      // Overflow: ten consecutive pushes, the tenth is dropped
      base = starts.size();
      for (int i = 0; i < 10; i++) begin
         push_vec(i, i < 9);
         if (i == 1) check("b_level_push_pop", 64'(queue_level), 64'd1);
         if (i == 8) begin
            check("b_level_full", 64'(queue_level), 64'd8);
            check("b_full", 64'(queue_full), 64'd1);
            check("b_no_overflow_yet", 64'(overflow), 64'd0);
         end
         if (i == 9) begin
            check("b_level_after_drop", 64'(queue_level), 64'd8);
            check("b_overflow_set", 64'(overflow), 64'd1);
         end
      end
      overflow_clr = 1'b1;
      push_vec(9, 1'b0);
      overflow_clr = 1'b0;
      check("b_set_wins_clear", 64'(overflow), 64'd1);
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      check("b_overflow_cleared", 64'(overflow), 64'd0);
      for (int k = 0; k < 9; k++) wait_done(PKT_CYC + 40, d0);
      repeat (6) step();
      check("b_nine_packets", 64'(starts.size() - base), 64'(9 * NB));
      check("b_idle_after", 64'(busy), 64'd0);

      // Two queued packets: inter-packet line-high time
      base = starts.size();
      push_vec(4, 1'b1);
      push_vec(7, 1'b1);
      wait_done(PKT_CYC + 40, d0);
      wait_done(PKT_CYC + 40, d1);
      check("c_done_spacing", 64'(d1 - d0), 64'(PKT_CYC + 5));
      check("c_byte_count", 64'(starts.size() - base), 64'(2 * NB));
      check("c_line_high_gap", 64'(starts[base + NB] - (starts[base + NB - 1] + 36)), 64'd9);
      repeat (6) step();

      // Push and pop in the same cycle at level 3
      push_vec(1, 1'b1);
      step();
      push_vec(2, 1'b1);
      push_vec(3, 1'b1);
      push_vec(5, 1'b1);
      check("d_level3", 64'(queue_level), 64'd3);
      wait_done(PKT_CYC + 40, d0);
      step();
      step();
      step();
      check("d_level_before", 64'(queue_level), 64'd3);
      push_vec(6, 1'b1);
      check("d_level_push_pop", 64'(queue_level), 64'd3);
      check("d_overflow", 64'(overflow), 64'd0);
      for (int k = 0; k < 4; k++) wait_done(PKT_CYC + 40, d0);
      repeat (6) step();

      // Reset mid-byte with three packets queued
      push_vec(0, 1'b1);
      push_vec(1, 1'b1);
      push_vec(2, 1'b1);
      push_vec(3, 1'b1);
      repeat (30) step();
      rst = 1'b1;
      #1;
      check("e_tx_idle", 64'(tx_line), 64'd1);
      check("e_empty", 64'(queue_empty), 64'd1);
      check("e_level", 64'(queue_level), 64'd0);
      check("e_busy", 64'(busy), 64'd0);
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
      sc = starts.size();
      repeat (300) step();
      check("e_no_frames", 64'(starts.size()), 64'(sc));
      check("e_line_high", 64'(tx_line), 64'd1);
      push_vec(8, 1'b1);
      wait_done(PKT_CYC + 40, d0);
      repeat (6) step();
      check("e_resume_bytes", 64'(starts.size() - sc), 64'(NB));
      check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
